fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
// - Front-end fetch pipeline stage: owns the PC, issues in-order word reads to instruction memory.
// - Buffers responses and drives stage::InsnBundle {valid, addr, insn} into the read stage.
// - Producer end of the InsnBundle interface; the read stage registers whatever this block presents.
// - Handles downstream stall and redirect (branch/exception) with flush of in-flight fetches.
// PARAMETERS
// - ADDR_WIDTH  32            byte-address width; PC and all addr fields are word addresses, [ADDR_WIDTH-1:2].
// - RESET_ADDR  32'h0000_0000 byte address fetched first after reset; bits [1:0] must be 0.
// - FIFO_DEPTH  2             response buffer entries, power of 2, >=2; also max in-flight requests.
// PORTS
// - clk             in   1             clock; all logic on posedge.
// - rst             in   1             reset, synchronous, active-high.
// - redirect_valid  in   1             restart fetch at redirect_addr.
// - redirect_addr   in   ADDR_WIDTH-2  new word PC.
// - stall           in   1             downstream cannot take a new bundle; hold stage_out_insn.
// - mem_req_valid   out  1             read request valid.
// - mem_req_addr    out  ADDR_WIDTH-2  request word address.
// - mem_req_ready   in   1             memory accepts request this cycle.
// - mem_rsp_valid   in   1             read data valid; responses in request order, >=1 cycle after accept.
// - mem_rsp_data    in   32            instruction word.
// - stage_out_insn  out  InsnBundle    registered bundle to read stage; .addr is word address.
// BEHAVIOUR
// - Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
// - Reset values:
//   - pc = RESET_ADDR>>2, state = FETCH, FIFO empty, outstanding = 0, stale = 0.
//   - mem_req_valid = 0; stage_out_insn.valid = 0 (.addr/.insn = 0).
// - Credits: mem_req_valid = (state==FETCH) && (outstanding + fifo_count < FIFO_DEPTH); mem_req_addr = pc.
//   - Accept = mem_req_valid && mem_req_ready: pc += 1 (wraps modulo 2^(ADDR_WIDTH-2)).
//   - On accept, the request address is pushed to the address queue and outstanding += 1.
// - Request hold: while mem_req_valid && !mem_req_ready, address is held stable.
//   - Only rst or redirect_valid may withdraw an unaccepted request.
// - Response: mem_rsp_valid with stale==0 pushes {addr queue head, data} into FIFO; outstanding -= 1.
//   - Response with stale>0 is discarded; stale -= 1, outstanding -= 1.
// - Output: when !stall, stage_out_insn <= FIFO head (pop) if FIFO nonempty, else valid <= 0.
//   - When stall, stage_out_insn holds all fields.
// - Latency: response in cycle M into empty FIFO, stall=0 -> stage_out_insn.valid=1 in cycle M+2.
//   - Steady state: 1 bundle/cycle when memory returns 1 response/cycle.
// - FSM:
//   - FETCH: normal issue; on redirect_valid -> DRAIN if in-flight after this edge >0, else stay FETCH.
//   - DRAIN: no requests; go to FETCH when stale reaches 0.
//   - A redirect in DRAIN re-targets pc and stays in DRAIN.
// - Redirect (in any state, overrides stall):
//   - pc <= redirect_addr; FIFO and address queue flushed.
//   - stage_out_insn.valid <= 0 next cycle.
//   - stale <= all in-flight requests, including one accepted in the same cycle.
// - Simultaneous events:
//   - Redirect + mem_rsp_valid in the same cycle: the response is counted stale and dropped.
//   - Redirect + accept in the same cycle: the accepted request is stale; pc still takes redirect_addr.
//   - Push and pop in the same cycle with FIFO full: legal, count unchanged.
// - Error: mem_rsp_valid with outstanding==0 -> $error; response ignored.
// - Reset mid-operation: state returns to reset values next cycle.
//   - Responses arriving after reset are not tracked; the memory must be reset together with this block.
// CONFIGURATION
// - FETCH_TRACE_EN defined:
//   - `MSG(5, "FETCH: addr=%h op=%h") on each new valid bundle (byte address).
//   - `MSG(5, "FETCH: redirect %h") on each redirect.
// - FETCH_TRACE_EN undefined: no messages; cycle behaviour identical.
// TESTING
// - Reset, mem always ready, 1-cycle response: mem_req_addr 0,1,2...; out addr 0,1,2 with matching insn; valid from cycle 3.
// - mem_req_ready=0 for 5 cycles: mem_req_addr stays 0x0, pc unchanged; no out valid until accept.
// - stall=1 for 4 cycles after FIFO full: out bundle held; requests stop at FIFO_DEPTH in flight; resume in order.
// - 2 in flight, redirect to 0x40: both responses dropped, DRAIN 2 cycles, next out addr=0x40, no 0x2/0x3 delivered.
// - Redirect coinciding with mem_rsp_valid and accept: both stale; out valid=0 next cycle; first bundle addr=redirect_addr.
// - RESET_ADDR=32'hFFFF_FFFC, ADDR_WIDTH=32: out addr 0x3FFF_FFFF then wraps to 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order word reads to instruction memory, buffers responses
// and presents stage::InsnBundle to the read stage. Define FETCH_TRACE_EN for fetch/redirect trace messages.
package stage;
  localparam int BUNDLE_ADDR_WIDTH = 30;

  typedef struct packed {
    logic                         valid;
    logic [BUNDLE_ADDR_WIDTH-1:0] addr;
    logic [31:0]                  insn;
  } InsnBundle;
endpackage

module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  input  logic                  stall,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-3:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  output stage::InsnBundle      stage_out_insn
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BAW   = stage::BUNDLE_ADDR_WIDTH;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t            state, state_next;
  logic [WA-1:0]     pc;
  logic [CNT_W-1:0]  outstanding, stale, fifo_count;
  logic [CNT_W-1:0]  inflight_next, stale_next;
  logic [CNT_W:0]    in_use;
  logic [PTR_W-1:0]  fifo_rd, fifo_wr, aq_rd, aq_wr;
  logic [WA-1:0]     fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [WA-1:0]     aq_addr   [FIFO_DEPTH];
  logic              accept, rsp, push, pop;

  // Outstanding requests plus buffered words never exceed FIFO_DEPTH, so a push never finds the FIFO full.
  always_comb begin
    in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
    mem_req_valid = !rst && (state == FETCH) && (in_use < DEPTH_C);
    mem_req_addr  = pc;
    accept        = mem_req_valid && mem_req_ready;
    rsp           = mem_rsp_valid && (outstanding != '0);
    push          = rsp && !redirect_valid && (stale == '0);
    pop           = !redirect_valid && !stall && (fifo_count != '0);
    inflight_next = outstanding + CNT_W'(accept) - CNT_W'(rsp);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    stale_next = stale;
    if (redirect_valid) begin
      stale_next = inflight_next;
      state_next = (inflight_next != '0) ? DRAIN : FETCH;
    end else begin
      if (rsp && (stale != '0)) stale_next = stale - CNT_W'(1);
      if ((state == DRAIN) && (stale_next == '0)) state_next = FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_ADDR[ADDR_WIDTH-1:2];
      outstanding    <= '0;
      stale          <= '0;
      fifo_rd        <= '0;
      fifo_wr        <= '0;
      fifo_count     <= '0;
      aq_rd          <= '0;
      aq_wr          <= '0;
      stage_out_insn <= '0;
    end else begin
      assert (!(mem_rsp_valid && (outstanding == '0)))
        else $error("fetch_stage: response with no request outstanding");

      state       <= state_next;
      stale       <= stale_next;
      outstanding <= inflight_next;

      if (redirect_valid) pc <= redirect_addr;
      else if (accept)    pc <= pc + WA'(1);

      // A request accepted in the redirect cycle is stale, so it never enters the address queue.
      if (redirect_valid) begin
        aq_rd <= '0;
        aq_wr <= '0;
      end else begin
        if (accept) aq_wr <= aq_wr + PTR_W'(1);
        if (push)   aq_rd <= aq_rd + PTR_W'(1);
      end

      if (redirect_valid) begin
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        fifo_count <= '0;
      end else begin
        if (push) fifo_wr <= fifo_wr + PTR_W'(1);
        if (pop)  fifo_rd <= fifo_rd + PTR_W'(1);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end

      if (redirect_valid) begin
        stage_out_insn.valid <= 1'b0;
      end else if (!stall) begin
        if (pop) stage_out_insn <= '{valid: 1'b1, addr: BAW'(fifo_addr[fifo_rd]), insn: fifo_data[fifo_rd]};
        else     stage_out_insn.valid <= 1'b0;
      end
    end
  end

  // NOTE: buffer storage has no reset; pointers and counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (accept && !redirect_valid) aq_addr[aq_wr] <= pc;
    if (push) begin
      fifo_addr[fifo_wr] <= aq_addr[aq_rd];
      fifo_data[fifo_wr] <= mem_rsp_data;
    end
  end

`ifdef FETCH_TRACE_EN
  `ifndef MSG
    `define MSG(level, args) $display args
  `endif
  always_ff @(posedge clk) begin
    if (!rst && redirect_valid)
      `MSG(5, ("FETCH: redirect %h", {redirect_addr, 2'b00}));
    if (!rst && pop)
      `MSG(5, ("FETCH: addr=%h op=%h", {fifo_addr[fifo_rd], 2'b00}, fifo_data[fifo_rd]));
  end
`endif

endmodule
